// File: rtl/bin2bcd_seq.sv
// Purpose: sequential binary-to-packed-BCD converter (shift-and-add-3, one bit per cycle).
// Latency: START accepted at cycle 0 -> VALID/DOUT at cycle IN_W+1; next START accepted the cycle after VALID.
// Backpressure: none; START is only sampled in IDLE, requests while BUSY are dropped.
// Optional: define BIN2BCD_LZ_BLANK_EN to add the BLANK leading-zero mask output.
module bin2bcd_seq #(
  parameter int IN_W   = 27,
  parameter int DIGITS = 8
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic                  START,
  input  logic [IN_W-1:0]       DIN,
  output logic                  BUSY,
  output logic                  VALID,
  output logic                  OVF,
  output logic [4*DIGITS-1:0]   DOUT
`ifdef BIN2BCD_LZ_BLANK_EN
  ,
  output logic [DIGITS-1:0]     BLANK
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  // Largest value representable in DIGITS decimal digits, one bit wider than DIN.
  localparam logic [IN_W:0] MAX_VAL = (IN_W + 1)'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state;
  logic [IN_W-1:0]    shift_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               ovf_pend;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;

  // Add-3 correction on every digit >= 5, then shift the next binary MSB into digit 0.
  // Correction precedes the shift, so a 4-bit add never carries out of its digit.
  always_comb begin
    bcd_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      bcd_adj[4*d +: 4] = (bcd_reg[4*d +: 4] >= 4'd5) ? bcd_reg[4*d +: 4] + 4'd3
                                                      : bcd_reg[4*d +: 4];
    end
    bcd_next = {bcd_adj[BCD_W-2:0], shift_reg[IN_W-1]};
  end

`ifdef BIN2BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic              nz_seen;

  // Blank each digit above the most significant nonzero one; digit 0 always shows.
  always_comb begin
    blank_next = '0;
    nz_seen    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (bcd_next[4*i +: 4] != 4'd0) nz_seen = 1'b1;
      blank_next[i] = ~nz_seen;
    end
  end
`endif

  // Control FSM; outputs are registered and loaded on the final shift edge so that
  // the DONE cycle presents VALID together with the new DOUT/OVF.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bcd_reg   <= '0;
      bit_cnt   <= '0;
      ovf_pend  <= 1'b0;
      BUSY      <= 1'b0;
      VALID     <= 1'b0;
      OVF       <= 1'b0;
      DOUT      <= '0;
`ifdef BIN2BCD_LZ_BLANK_EN
      BLANK     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          VALID <= 1'b0;
          if (START) begin
            shift_reg <= DIN;
            bcd_reg   <= '0;
            bit_cnt   <= CNT_W'(IN_W);
            ovf_pend  <= ({1'b0, DIN} > MAX_VAL);
            BUSY      <= 1'b1;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_reg   <= bcd_next;
          shift_reg <= {shift_reg[IN_W-2:0], 1'b0};
          bit_cnt   <= bit_cnt - CNT_W'(1);
          if (bit_cnt == CNT_W'(1)) begin
            BUSY  <= 1'b0;
            VALID <= 1'b1;
            OVF   <= ovf_pend;
            DOUT  <= ovf_pend ? {DIGITS{4'h9}} : bcd_next;
`ifdef BIN2BCD_LZ_BLANK_EN
            BLANK <= ovf_pend ? '0 : blank_next;
`endif
            state <= S_DONE;
          end
        end
        S_DONE: begin
          VALID <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          VALID <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: randomized and directed conversions against an arithmetic model.
// Checks latency, handshake, overflow saturation, START-while-busy, back-to-back and async reset.
// Optional BLANK checks are compiled when BIN2BCD_LZ_BLANK_EN is defined.
module tb_bin2bcd_seq;

  logic        CLK;
  logic        RST_X;
  logic        START;
  logic [26:0] DIN;
  logic        BUSY;
  logic        VALID;
  logic        OVF;
  logic [31:0] DOUT;
`ifdef BIN2BCD_LZ_BLANK_EN
  logic [7:0]  BLANK;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bin2bcd_seq #(.IN_W(27), .DIGITS(8)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .START (START),
    .DIN   (DIN),
    .BUSY  (BUSY),
    .VALID (VALID),
    .OVF   (OVF),
    .DOUT  (DOUT)
`ifdef BIN2BCD_LZ_BLANK_EN
    ,
    .BLANK (BLANK)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Decimal digits of v, saturated to all nines above 99,999,999.
  function automatic logic [31:0] ref_bcd(input logic [26:0] v);
    int unsigned x;
    logic [31:0] r;
    x = v;
    r = '0;
    if (x > 99999999) return 32'h99999999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [26:0] v);
    int unsigned x;
    x = v;
    return (x > 99999999);
  endfunction

  // Digits at or above the decimal length of v are blanked (length of 0 is 1).
  function automatic logic [7:0] ref_blank(input logic [26:0] v);
    int unsigned y;
    int nd;
    logic [7:0] b;
    y = v;
    if (y > 99999999) return 8'h00;
    nd = 1;
    while (y >= 10) begin
      y = y / 10;
      nd++;
    end
    for (int i = 0; i < 8; i++) b[i] = (i >= nd);
    return b;
  endfunction

  // Issue one START pulse and observe the resulting VALID cycle.
  task automatic do_conv(input logic [26:0] din, output int lat, output logic [31:0] dout,
                         output logic ovf, output int busy_bad, output logic one_pulse,
                         output logic [7:0] blank);
    lat = -1; dout = '0; ovf = 1'b0; busy_bad = 0; blank = '0;
    @(negedge CLK);
    START = 1'b1;
    DIN   = din;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (VALID) begin
        lat  = c;
        dout = DOUT;
        ovf  = OVF;
`ifdef BIN2BCD_LZ_BLANK_EN
        blank = BLANK;
`endif
        if (BUSY) busy_bad++;
        break;
      end
      if (!BUSY) busy_bad++;
      @(negedge CLK);
    end
    @(negedge CLK);
    one_pulse = !VALID;
  endtask

  task automatic test_reset();
    RST_X = 1'b1;
    START = 1'b0;
    DIN   = '0;
    #2 RST_X = 1'b0;
    #1;
    n_tests++;
    if ({BUSY, VALID, OVF} !== 3'b000 || DOUT !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async busy=%b valid=%b ovf=%b dout=%h, required 0/0/0/00000000", BUSY, VALID, OVF, DOUT);
    end
    repeat (3) @(negedge CLK);
    n_tests++;
    if ({BUSY, VALID, OVF} !== 3'b000 || DOUT !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold busy=%b valid=%b ovf=%b dout=%h, required 0/0/0/00000000", BUSY, VALID, OVF, DOUT);
    end
    RST_X = 1'b1;
  endtask

  task automatic test_directed();
    logic [26:0] vals [6];
    int lat, bb;
    logic [31:0] d;
    logic o, p;
    logic [7:0] bl;
    vals = '{27'd0, 27'd12345678, 27'd99999999, 27'd100000000, 27'd134217727, 27'd5};
    foreach (vals[k]) begin
      do_conv(vals[k], lat, d, o, bb, p, bl);
      n_tests++;
      if (lat !== 28) begin
        n_fail++;
        $display("FAIL dir_latency din=%0d got=%0d required=28", vals[k], lat);
      end
      n_tests++;
      if (d !== ref_bcd(vals[k]) || o !== ref_ovf(vals[k])) begin
        n_fail++;
        $display("FAIL dir_result din=%0d got=%h/%b required=%h/%b", vals[k], d, o, ref_bcd(vals[k]), ref_ovf(vals[k]));
      end
      n_tests++;
      if (bb !== 0 || p !== 1'b1) begin
        n_fail++;
        $display("FAIL dir_handshake din=%0d busy_errors=%0d single_pulse=%b required 0/1", vals[k], bb, p);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] d0;
    logic o0;
    int bad;
    d0 = DOUT;
    o0 = OVF;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      DIN = 27'($urandom);
      if (DOUT !== d0 || OVF !== o0 || VALID !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_stable changes=%0d required=0", bad);
    end
  endtask

  task automatic test_random();
    logic [26:0] v;
    int lat, bb;
    logic [31:0] d;
    logic o, p;
    logic [7:0] bl;
    int bad;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        0: v = 27'($urandom_range(134217727, 0));
        1: v = 27'($urandom_range(999, 0));
        2: v = 27'($urandom_range(99999999, 99999000));
        default: v = 27'($urandom_range(100001000, 99999990));
      endcase
      do_conv(v, lat, d, o, bb, p, bl);
      n_tests++;
      if (lat !== 28 || d !== ref_bcd(v) || o !== ref_ovf(v) || bb !== 0 || !p) begin
        n_fail++;
        $display("FAIL rand_conv din=%0d got lat=%0d dout=%h ovf=%b busy_err=%0d required lat=28 dout=%h ovf=%b",
                 v, lat, d, o, bb, ref_bcd(v), ref_ovf(v));
      end
`ifdef BIN2BCD_LZ_BLANK_EN
      if (bl !== ref_blank(v)) bad++;
`endif
    end
`ifdef BIN2BCD_LZ_BLANK_EN
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rand_blank errors=%0d required=0", bad);
    end
`endif
  endtask

  task automatic test_busy_ignore();
    int nvalid, first_c;
    logic [31:0] d;
    nvalid = 0; first_c = -1; d = '0;
    @(negedge CLK);
    START = 1'b1;
    DIN   = 27'd42;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      START = (c == 10);
      if (c == 10) DIN = 27'd7;
      if (VALID) begin
        nvalid++;
        if (first_c < 0) begin
          first_c = c;
          d = DOUT;
        end
      end
      @(negedge CLK);
    end
    START = 1'b0;
    n_tests++;
    if (nvalid !== 1 || first_c !== 28 || d !== 32'h00000042) begin
      n_fail++;
      $display("FAIL busy_ignore valids=%0d at=%0d dout=%h required 1 at 28 dout=00000042", nvalid, first_c, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] vals [5];
    int c, last, found;
    for (int k = 0; k < 5; k++) vals[k] = 27'($urandom_range(134217727, 0));
    vals[2] = 27'($urandom_range(9999, 0));
    c = 0; last = 0;
    @(negedge CLK);
    START = 1'b1;
    DIN   = vals[0];
    for (int k = 0; k < 5; k++) begin
      found = 0;
      for (int w = 0; w < 40; w++) begin
        @(negedge CLK);
        c++;
        if (VALID) begin
          found = 1;
          break;
        end
      end
      n_tests++;
      if (found == 0 || (c - last) !== ((k == 0) ? 28 : 29)) begin
        n_fail++;
        $display("FAIL b2b_spacing k=%0d found=%0d gap=%0d required=%0d", k, found, c - last, (k == 0) ? 28 : 29);
      end
      n_tests++;
      if (DOUT !== ref_bcd(vals[k]) || OVF !== ref_ovf(vals[k])) begin
        n_fail++;
        $display("FAIL b2b_result k=%0d din=%0d got=%h/%b required=%h/%b", k, vals[k], DOUT, OVF, ref_bcd(vals[k]), ref_ovf(vals[k]));
      end
      last = c;
      if (k < 4) DIN = vals[k+1];
      else START = 1'b0;
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    int lat, bb;
    logic [31:0] d;
    logic o, p;
    logic [7:0] bl;
    @(negedge CLK);
    START = 1'b1;
    DIN   = 27'd54321;
    @(negedge CLK);
    START = 1'b0;
    repeat (14) @(negedge CLK);
    #2 RST_X = 1'b0;
    #1;
    n_tests++;
    if ({BUSY, VALID, OVF} !== 3'b000 || DOUT !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid busy=%b valid=%b ovf=%b dout=%h required 0/0/0/00000000", BUSY, VALID, OVF, DOUT);
    end
    @(negedge CLK);
    RST_X = 1'b1;
    do_conv(27'd9, lat, d, o, bb, p, bl);
    n_tests++;
    if (lat !== 28 || d !== 32'h00000009 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_recover lat=%0d dout=%h ovf=%b required 28/00000009/0", lat, d, o);
    end
  endtask

`ifdef BIN2BCD_LZ_BLANK_EN
  task automatic test_blank();
    logic [26:0] vals [4];
    logic [7:0] req [4];
    int lat, bb;
    logic [31:0] d;
    logic o, p;
    logic [7:0] bl;
    vals = '{27'd42, 27'd0, 27'd10000000, 27'd120000000};
    req  = '{8'b11111100, 8'b11111110, 8'b00000000, 8'b00000000};
    foreach (vals[k]) begin
      do_conv(vals[k], lat, d, o, bb, p, bl);
      n_tests++;
      if (bl !== req[k]) begin
        n_fail++;
        $display("FAIL blank din=%0d got=%b required=%b", vals[k], bl, req[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef BIN2BCD_LZ_BLANK_EN
    test_blank();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
